cpu: RTL and testbench



---
 rtl/cpu.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_cpu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu -- 5-stage pipelined 32-bit MIPS-subset processor (IF, ID, EX, MEM, WB).
//
// Instruction memory is filled serially while LoadInstructions is high.
// Execution starts from address 0 once it drops. Register file, data memory
// and all pipeline state live inside. The only externally visible result is
// the registered write-back value.
//
// Supported: add, sub, and, or, slt (R-type), addi, lw, sw, beq.
// Every other encoding executes as a NOP.
//
// Ports
//   clk               rising-edge system clock
//   Reset             asynchronous, active-high reset (imem is preserved)
//   LoadInstructions  1: load mode, Instruction is written to imem[ptr++]
//   Instruction       instruction word written in load mode
//   out               data of the most recent retiring register write
// -----------------------------------------------------------------------------
module cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        LoadInstructions,
  input  logic [31:0] Instruction,
  output logic [31:0] out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Decoded control carried from ID into EX. All-zero is a bubble.
  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    alusrc;   // 1: second ALU operand is the sign-extended immediate
    alu_op_e alu;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0]    imem [IMEM_DEPTH];
  logic [31:0]    dmem [DMEM_DEPTH];
  logic [31:0]    rf   [32];
  logic [IAW-1:0] load_ptr;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [31:0] pc;

  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  ctrl_t       idex_ctrl;
  logic [31:0] idex_pc;
  logic [31:0] idex_rs_val;
  logic [31:0] idex_rt_val;
  logic [31:0] idex_imm;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [4:0]  idex_dst;

  logic        exmem_regwrite;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic [31:0] exmem_alu;
  logic [31:0] exmem_store;
  logic [4:0]  exmem_dst;

  logic        memwb_regwrite;
  logic [31:0] memwb_data;
  logic [4:0]  memwb_dst;

  // ---------------------------------------------------------------------------
  // IF
  // ---------------------------------------------------------------------------
  logic [31:0] if_instr;
  assign if_instr = imem[pc[IAW+1:2]];

  // ---------------------------------------------------------------------------
  // ID: decode, register read, load-use hazard detection
  // ---------------------------------------------------------------------------
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  ctrl_t       id_ctrl;
  logic [4:0]  id_dst;
  logic        id_uses_rs;
  logic        id_uses_rt;

  assign id_op    = ifid_instr[31:26];
  assign id_rs    = ifid_instr[25:21];
  assign id_rt    = ifid_instr[20:16];
  assign id_rd    = ifid_instr[15:11];
  assign id_funct = ifid_instr[5:0];
  assign id_imm   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    id_ctrl    = BUBBLE;
    id_dst     = '0;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    unique case (id_op)
      OP_RTYPE: begin
        id_ctrl.regwrite = 1'b1;
        id_dst           = id_rd;
        id_uses_rs       = 1'b1;
        id_uses_rt       = 1'b1;
        unique case (id_funct)
          FN_ADD:  id_ctrl.alu = ALU_ADD;
          FN_SUB:  id_ctrl.alu = ALU_SUB;
          FN_AND:  id_ctrl.alu = ALU_AND;
          FN_OR:   id_ctrl.alu = ALU_OR;
          FN_SLT:  id_ctrl.alu = ALU_SLT;
          default: begin
            id_ctrl    = BUBBLE;
            id_dst     = '0;
            id_uses_rs = 1'b0;
            id_uses_rt = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        id_dst           = id_rt;
        id_uses_rs       = 1'b1;
      end
      OP_LW: begin
        id_ctrl.regwrite = 1'b1;
        id_ctrl.memread  = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        id_dst           = id_rt;
        id_uses_rs       = 1'b1;
      end
      OP_SW: begin
        id_ctrl.memwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        id_uses_rs       = 1'b1;
        id_uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        id_ctrl.branch = 1'b1;
        id_uses_rs     = 1'b1;
        id_uses_rt     = 1'b1;
      end
      default: ;
    endcase
  end

  // A WB write to a nonzero register; also bypassed into the same-cycle ID read.
  logic wb_we;
  assign wb_we = memwb_regwrite && (memwb_dst != 5'd0) && !LoadInstructions;

  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  assign id_rs_val = (wb_we && memwb_dst == id_rs) ? memwb_data : rf[id_rs];
  assign id_rt_val = (wb_we && memwb_dst == id_rt) ? memwb_data : rf[id_rt];

  // A lw in EX cannot forward its data yet: hold IF/ID one cycle.
  logic stall;
  assign stall = idex_ctrl.memread && (idex_dst != 5'd0) &&
                 ((id_uses_rs && id_rs == idex_dst) ||
                  (id_uses_rt && id_rt == idex_dst));

  // ---------------------------------------------------------------------------
  // EX: forwarding, ALU, branch resolution
  // ---------------------------------------------------------------------------
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        ex_taken;
  logic [31:0] ex_target;

  // EX/MEM has priority: it holds the younger of the two in-flight writers.
  always_comb begin
    fwd_a = idex_rs_val;
    if (exmem_regwrite && exmem_dst != 5'd0 && exmem_dst == idex_rs)
      fwd_a = exmem_alu;
    else if (memwb_regwrite && memwb_dst != 5'd0 && memwb_dst == idex_rs)
      fwd_a = memwb_data;
  end

  always_comb begin
    fwd_b = idex_rt_val;
    if (exmem_regwrite && exmem_dst != 5'd0 && exmem_dst == idex_rt)
      fwd_b = exmem_alu;
    else if (memwb_regwrite && memwb_dst != 5'd0 && memwb_dst == idex_rt)
      fwd_b = memwb_data;
  end

  assign alu_b = idex_ctrl.alusrc ? idex_imm : fwd_b;

  always_comb begin
    alu_result = '0;
    unique case (idex_ctrl.alu)
      ALU_ADD: alu_result = fwd_a + alu_b;
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end

  assign ex_taken  = idex_ctrl.branch && (fwd_a == fwd_b);
  assign ex_target = idex_pc + 32'd4 + {idex_imm[29:0], 2'b00};

  // ---------------------------------------------------------------------------
  // MEM
  // ---------------------------------------------------------------------------
  logic [DAW-1:0] mem_addr;
  logic [31:0]    mem_rdata;
  assign mem_addr  = exmem_alu[DAW-1:0];
  assign mem_rdata = dmem[mem_addr];

  // ---------------------------------------------------------------------------
  // Pipeline sequencing
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every stage reads
  // the previous cycle's values regardless of statement order.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc             <= '0;
      ifid_instr     <= '0;
      ifid_pc        <= '0;
      idex_ctrl      <= BUBBLE;
      idex_pc        <= '0;
      idex_rs_val    <= '0;
      idex_rt_val    <= '0;
      idex_imm       <= '0;
      idex_rs        <= '0;
      idex_rt        <= '0;
      idex_dst       <= '0;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_alu      <= '0;
      exmem_store    <= '0;
      exmem_dst      <= '0;
      memwb_regwrite <= 1'b0;
      memwb_data     <= '0;
      memwb_dst      <= '0;
      out            <= '0;
    end else if (LoadInstructions) begin
      // Execution is held: PC parked at 0, every stage drained to a bubble.
      pc             <= '0;
      ifid_instr     <= '0;
      idex_ctrl      <= BUBBLE;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      memwb_regwrite <= 1'b0;
    end else begin
      // IF -> ID. A taken branch squashes the fetched instruction (all-zero
      // word decodes as NOP); a stall holds PC and IF/ID.
      if (ex_taken) begin
        pc         <= ex_target;
        ifid_instr <= '0;
      end else if (!stall) begin
        pc         <= pc + 32'd4;
        ifid_instr <= if_instr;
        ifid_pc    <= pc;
      end

      // ID -> EX. Data fields are don't-care when a bubble is injected.
      idex_ctrl   <= (ex_taken || stall) ? BUBBLE : id_ctrl;
      idex_pc     <= ifid_pc;
      idex_rs_val <= id_rs_val;
      idex_rt_val <= id_rt_val;
      idex_imm    <= id_imm;
      idex_rs     <= id_rs;
      idex_rt     <= id_rt;
      idex_dst    <= id_dst;

      // EX -> MEM
      exmem_regwrite <= idex_ctrl.regwrite;
      exmem_memread  <= idex_ctrl.memread;
      exmem_memwrite <= idex_ctrl.memwrite;
      exmem_alu      <= alu_result;
      exmem_store    <= fwd_b;
      exmem_dst      <= idex_dst;

      // MEM -> WB
      memwb_regwrite <= exmem_regwrite;
      memwb_data     <= exmem_memread ? mem_rdata : exmem_alu;
      memwb_dst      <= exmem_dst;

      // WB. Writes aimed at r0 still retire and are shown on out.
      if (memwb_regwrite) out <= memwb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_dst] <= memwb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory and instruction memory
  // ---------------------------------------------------------------------------
  // NOTE: data memory has a reset value (word i = i), so it is built from
  // resettable flops; instruction memory must survive reset and therefore
  // lives in a block with no reset at all.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'(i);
    end else if (exmem_memwrite && !LoadInstructions) begin
      dmem[mem_addr] <= exmem_store;
    end
  end

  always_ff @(posedge clk) begin
    if (LoadInstructions && !Reset) imem[load_ptr] <= Instruction;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      load_ptr <= '0;
    end else if (LoadInstructions) begin
      load_ptr <= (load_ptr == IAW'(IMEM_DEPTH - 1)) ? '0 : load_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu -- scoreboard bench for cpu.
// Stimulus loads hand-assembled programs and pushes the write-back values they
// must produce into a queue. A monitor pops one entry each time the core
// retires a register write and compares it against out.
// -----------------------------------------------------------------------------
module tb_cpu;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        LoadInstructions = 1'b0;
  logic [31:0] Instruction = '0;
  logic [31:0] out;

  cpu dut (
    .clk              (clk),
    .Reset            (Reset),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .out              (out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] expq[$];      // scoreboard: values out must show, in order
  logic [31:0] prog[$];      // program image for the next load
  logic [31:0] exp_vals[$];  // staging list for queue_expected()

  localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND = 6'h24, OR = 6'h25, SLT = 6'h2A;
  localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;

  function automatic logic [31:0] r_op(input int rd, input int rs, input int rt,
                                       input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  // I-format: op rt, rs, imm (for beq the two register fields are rs, rt)
  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt,
                                       input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, got, got, want, want);
    end
  endtask

  task automatic queue_expected();
    foreach (exp_vals[i]) expq.push_back(exp_vals[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 Reset = 1'b1;
    LoadInstructions = 1'b0;
    #1 check("out after reset", out, 32'd0);
    @(negedge clk);
    #1 Reset = 1'b0;
  endtask

  // Reset, then write 64 words (program padded with NOPs) through the load port.
  task automatic load_prog();
    do_reset();
    LoadInstructions = 1'b1;
    for (int i = 0; i < 64; i++) begin
      Instruction = (i < prog.size()) ? prog[i] : 32'd0;
      @(negedge clk);
    end
    check("out held during load", out, 32'd0);
    LoadInstructions = 1'b0;
  endtask

  // Let the program run for a bounded number of cycles, then every expected
  // retirement must have been consumed by the monitor.
  task automatic run(input int cycles, input string name);
    repeat (cycles) @(negedge clk);
    #1 check({"pending retirements after ", name}, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  // Monitor: memwb_regwrite seen at a falling edge means out updates on the
  // next rising edge; compare on the following falling edge.
  initial begin : monitor
    logic pend;
    int   idx;
    pend = 1'b0;
    idx  = 0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected retire: out=%0d (0x%08h), nothing expected", out, out);
          end else begin
            check($sformatf("retire %0d", idx), out, expq.pop_front());
          end
          idx++;
        end
        pend = dut.memwb_regwrite;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // 1: two loads, rerun after a reset pulse with imem preserved.
    prog = '{i_op(LW, 10, 0, 100), i_op(LW, 12, 0, 120)};
    load_prog();
    exp_vals = '{32'd100, 32'd120};
    queue_expected();
    run(15, "lw pair");
    do_reset();
    queue_expected();
    run(15, "lw pair after reset");

    // 2: load-use stall then EX/MEM forward of R8.
    prog = '{i_op(LW, 7, 0, 70), i_op(LW, 12, 0, 120), i_op(LW, 2, 0, 20),
             r_op(8, 7, 2, ADD), r_op(9, 8, 2, ADD)};
    load_prog();
    exp_vals = '{32'd70, 32'd120, 32'd20, 32'd90, 32'd110};
    queue_expected();
    run(20, "forwarding");

    // 3: arithmetic chain, load-use on sub, store then reload.
    prog = '{i_op(ADDI, 1, 0, 423), i_op(ADDI, 2, 0, 92), i_op(ADDI, 3, 0, 13),
             i_op(ADDI, 4, 0, 146), i_op(ADDI, 5, 0, 5), r_op(5, 1, 4, ADD),
             r_op(6, 3, 5, SLT), i_op(LW, 4, 0, 4), r_op(7, 4, 6, SUB),
             i_op(SW, 7, 0, 0), i_op(LW, 9, 0, 0)};
    load_prog();
    exp_vals = '{32'd423, 32'd92, 32'd13, 32'd146, 32'd5, 32'd569, 32'd1,
                 32'd4, 32'd3, 32'd3};
    queue_expected();
    run(25, "program");

    // 4: taken beq skips two instructions; R2/R3 stay 0.
    prog = '{i_op(BEQ, 1, 1, 2), i_op(ADDI, 2, 0, 7), i_op(ADDI, 3, 0, 8),
             i_op(ADDI, 4, 0, 9), r_op(5, 2, 3, ADD)};
    load_prog();
    exp_vals = '{32'd9, 32'd0};
    queue_expected();
    run(20, "beq taken");

    // 5: beq with unequal operands (R2 forwarded) falls through.
    prog = '{i_op(ADDI, 1, 0, 1), i_op(ADDI, 2, 0, 2), i_op(BEQ, 2, 1, 2),
             i_op(ADDI, 3, 0, 3), i_op(ADDI, 4, 0, 4), r_op(5, 3, 4, ADD)};
    load_prog();
    exp_vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd7};
    queue_expected();
    run(20, "beq not taken");

    // 6: taken beq on forwarded operands, skip of one instruction.
    prog = '{i_op(ADDI, 1, 0, 5), i_op(ADDI, 2, 0, 5), i_op(BEQ, 2, 1, 1),
             i_op(ADDI, 3, 0, 99), i_op(ADDI, 4, 3, 4)};
    load_prog();
    exp_vals = '{32'd5, 32'd5, 32'd4};
    queue_expected();
    run(20, "beq taken forwarded");

    // 7: r0 writes, MEM/WB forward, WB->ID write-through, and/or/slt signed,
    //    negative offset wrapping the data address to 255.
    prog = '{i_op(ADDI, 0, 0, 77), r_op(1, 0, 0, ADD), i_op(ADDI, 3, 0, 10),
             32'd0, r_op(4, 3, 3, ADD), i_op(ADDI, 5, 0, -1), 32'd0, 32'd0,
             r_op(6, 5, 5, ADD), r_op(7, 5, 0, SLT), r_op(8, 5, 3, AND),
             r_op(9, 3, 5, OR), i_op(LW, 10, 0, -1)};
    load_prog();
    exp_vals = '{32'd77, 32'd0, 32'd10, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                 32'd1, 32'd10, 32'hFFFF_FFFF, 32'd255};
    queue_expected();
    run(25, "corner cases");

    // 8: asynchronous reset mid-program, then the same program reruns.
    prog = '{i_op(ADDI, 1, 0, 423), i_op(ADDI, 2, 0, 92), i_op(ADDI, 3, 0, 13),
             i_op(ADDI, 4, 0, 146), i_op(ADDI, 5, 0, 5), r_op(5, 1, 4, ADD),
             r_op(6, 3, 5, SLT), i_op(LW, 4, 0, 4), r_op(7, 4, 6, SUB),
             i_op(SW, 7, 0, 0), i_op(LW, 9, 0, 0)};
    load_prog();
    exp_vals = '{32'd423, 32'd92, 32'd13};
    queue_expected();
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1 Reset = 1'b1;
    #1 check("out right after mid-run reset", out, 32'd0);
    check("partial run retired", 32'(expq.size()), 32'd0);
    expq.delete();
    exp_vals = '{32'd423, 32'd92, 32'd13, 32'd146, 32'd5, 32'd569, 32'd1,
                 32'd4, 32'd3, 32'd3};
    queue_expected();
    @(negedge clk);
    #1 Reset = 1'b0;
    run(25, "rerun after mid-run reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
